// File: rtl/cr_cddip_sa_cnt_bank.sv
// SA statistics counter bank: N_CNT live counters fed by N_EVT event channels,
// with a bulk snapshot shadow bank, bulk clear and a one-cycle indirect read port.

module cr_cddip_sa_cnt_lane #(
   parameter int CNT_WIDTH = 50,
   parameter int SUM_W     = 60
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SUM_W-1:0]     inc_sum,
   input  logic                 clr_all,
   input  logic                 clr_one,
   input  logic                 sat_mode,
   input  logic                 snap,
   output logic [CNT_WIDTH-1:0] live,
   output logic [CNT_WIDTH-1:0] shadow,
   output logic                 ovf
);

   logic [SUM_W-1:0] nxt;
   logic             of;

   always_comb begin
      nxt = ((clr_all | clr_one) ? '0 : SUM_W'(live)) + inc_sum;
      of  = |nxt[SUM_W-1:CNT_WIDTH];
   end

   // Overflow beats a same-cycle bulk clear on the sticky flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live   <= '0;
         shadow <= '0;
         ovf    <= 1'b0;
      end else begin
         live <= (of && sat_mode) ? '1 : nxt[CNT_WIDTH-1:0];
         ovf  <= of | (ovf & ~clr_all);
         if (snap) shadow <= live;
      end
   end

endmodule

module cr_cddip_sa_cnt_bank #(
   parameter int N_CNT     = 64,
   parameter int CNT_WIDTH = 50,
   parameter int N_EVT     = 2,
   parameter int INC_WIDTH = 8,
   localparam int IDX_W    = (N_CNT > 1) ? $clog2(N_CNT) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_EVT-1:0]           evt_vld,
   input  logic [N_EVT*IDX_W-1:0]     evt_idx,
   input  logic [N_EVT*INC_WIDTH-1:0] evt_inc,
   input  logic                       snap,
   input  logic                       clear_live,
   input  logic [N_CNT-1:0]           sat_mode,
   input  logic                       rd_req,
   input  logic [IDX_W-1:0]           rd_addr,
   input  logic                       rd_src,
   input  logic                       rd_clr,
   output logic                       rd_ack,
   output logic                       rd_err,
   output logic [CNT_WIDTH-1:0]       rd_data,
   output logic [N_CNT-1:0]           ovf_flag
);

   localparam int SUM_W = CNT_WIDTH + INC_WIDTH + $clog2(N_EVT) + 1;

   typedef struct packed {
      logic                 ack;
      logic                 err;
      logic [CNT_WIDTH-1:0] data;
   } rd_rsp_t;

   logic [N_CNT-1:0][CNT_WIDTH-1:0] live_arr;
   logic [N_CNT-1:0][CNT_WIDTH-1:0] shadow_arr;
   logic                            rd_addr_ok;
   logic                            rd_live_clr;
   rd_rsp_t                         rsp_d, rsp_q;

   assign rd_addr_ok  = {1'b0, rd_addr} < (IDX_W+1)'(N_CNT);
   assign rd_live_clr = rd_req & rd_clr & ~rd_src & rd_addr_ok;

   genvar i;
   generate
      for (i = 0; i < N_CNT; i++) begin : g_cnt
         logic [SUM_W-1:0] sum;
         logic             clr_one;

         // Out-of-range channel indices match no lane and drop out naturally.
         always_comb begin
            sum = '0;
            for (int k = 0; k < N_EVT; k++)
               if (evt_vld[k] && evt_idx[k*IDX_W +: IDX_W] == IDX_W'(i))
                  sum = sum + SUM_W'(evt_inc[k*INC_WIDTH +: INC_WIDTH]);
         end

         assign clr_one = rd_live_clr && (rd_addr == IDX_W'(i));

         cr_cddip_sa_cnt_lane #(
            .CNT_WIDTH (CNT_WIDTH),
            .SUM_W     (SUM_W)
         ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .inc_sum  (sum),
            .clr_all  (clear_live),
            .clr_one  (clr_one),
            .sat_mode (sat_mode[i]),
            .snap     (snap),
            .live     (live_arr[i]),
            .shadow   (shadow_arr[i]),
            .ovf      (ovf_flag[i])
         );
      end
   endgenerate

   // Read samples pre-update state, so a same-cycle clear or snapshot is not visible.
   always_comb begin
      rsp_d      = '0;
      rsp_d.ack  = rd_req;
      rsp_d.err  = rd_req & ~rd_addr_ok;
      if (rd_req && rd_addr_ok)
         for (int k = 0; k < N_CNT; k++)
            if (rd_addr == IDX_W'(k))
               rsp_d.data = rd_src ? shadow_arr[k] : live_arr[k];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rsp_q <= '0;
      else     rsp_q <= rsp_d;
   end

   assign rd_ack  = rsp_q.ack;
   assign rd_err  = rsp_q.err;
   assign rd_data = rsp_q.data;

endmodule

// File: tb/tb_cr_cddip_sa_cnt_bank.sv
// Random + directed bench for cr_cddip_sa_cnt_bank against an array-based reference model.

module tb_cr_cddip_sa_cnt_bank;

   localparam int N_CNT = 12, CNT_WIDTH = 8, N_EVT = 2, INC_WIDTH = 8, IDX_W = 4;
   localparam int MAXV = (1 << CNT_WIDTH) - 1;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [N_EVT-1:0]           evt_vld;
   logic [N_EVT*IDX_W-1:0]     evt_idx;
   logic [N_EVT*INC_WIDTH-1:0] evt_inc;
   logic                       snap, clear_live;
   logic [N_CNT-1:0]           sat_mode;
   logic                       rd_req, rd_src, rd_clr;
   logic [IDX_W-1:0]           rd_addr;
   logic                       rd_ack, rd_err;
   logic [CNT_WIDTH-1:0]       rd_data;
   logic [N_CNT-1:0]           ovf_flag;

   always #5 clk = ~clk;

   cr_cddip_sa_cnt_bank #(
      .N_CNT(N_CNT), .CNT_WIDTH(CNT_WIDTH), .N_EVT(N_EVT), .INC_WIDTH(INC_WIDTH)
   ) dut (
      .clk(clk), .rst(rst), .evt_vld(evt_vld), .evt_idx(evt_idx), .evt_inc(evt_inc),
      .snap(snap), .clear_live(clear_live), .sat_mode(sat_mode),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_src(rd_src), .rd_clr(rd_clr),
      .rd_ack(rd_ack), .rd_err(rd_err), .rd_data(rd_data), .ovf_flag(ovf_flag)
   );

   int checks = 0, failures = 0;
   int m_live[N_CNT], m_snap[N_CNT];
   bit m_ovf[N_CNT];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [N_CNT-1:0] exp_ovf();
      logic [N_CNT-1:0] v;
      for (int i = 0; i < N_CNT; i++) v[i] = m_ovf[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_CNT; i++) begin
         m_live[i] = 0; m_snap[i] = 0; m_ovf[i] = 0;
      end
   endtask

   // One clock: drive, advance the model, then check the read port and flags.
   task automatic cyc(input int v0, i0, n0, v1, i1, n1, sn, cl, rq, ra, rs, rc);
      int ea, ee, ed, sum, nxt;
      bit clr_i, of;
      evt_vld    = {1'(v1), 1'(v0)};
      evt_idx    = {4'(i1), 4'(i0)};
      evt_inc    = {8'(n1), 8'(n0)};
      snap       = 1'(sn);
      clear_live = 1'(cl);
      rd_req     = 1'(rq);
      rd_addr    = 4'(ra);
      rd_src     = 1'(rs);
      rd_clr     = 1'(rc);
      ea = rq;
      ee = (rq != 0 && ra >= N_CNT) ? 1 : 0;
      ed = (rq != 0 && ee == 0) ? (rs != 0 ? m_snap[ra] : m_live[ra]) : 0;
      for (int i = 0; i < N_CNT; i++) begin
         sum = 0;
         if (v0 != 0 && i0 == i) sum += n0;
         if (v1 != 0 && i1 == i) sum += n1;
         clr_i = (cl != 0) || (rq != 0 && rc != 0 && rs == 0 && ra == i);
         nxt = (clr_i ? 0 : m_live[i]) + sum;
         of = nxt > MAXV;
         if (sn != 0) m_snap[i] = m_live[i];
         m_live[i] = !of ? nxt : (sat_mode[i] ? MAXV : nxt % (MAXV + 1));
         m_ovf[i] = of || (m_ovf[i] && cl == 0);
      end
      @(posedge clk); #1;
      chk("rd_ack", rd_ack, ea);
      chk("rd_err", rd_err, ee);
      chk("rd_data", rd_data, ed);
      chk("ovf_flag", ovf_flag, exp_ovf());
   endtask

   task automatic idle();
      cyc(0,0,0, 0,0,0, 0,0, 0,0,0,0);
   endtask

   task automatic inc1(input int idx, input int amt);
      cyc(1,idx,amt, 0,0,0, 0,0, 0,0,0,0);
   endtask

   task automatic rd(input int addr, input int src);
      cyc(0,0,0, 0,0,0, 0,0, 1,addr,src,0);
   endtask

   initial begin
      rst = 1'b1; evt_vld = '0; evt_idx = '0; evt_inc = '0; snap = 0; clear_live = 0;
      sat_mode = '0; rd_req = 0; rd_addr = '0; rd_src = 0; rd_clr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ack", rd_ack, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_ovf", ovf_flag, 0);

      rd(5, 0);
      chk("tp_rd5_ack", rd_ack, 1);
      chk("tp_rd5_data", rd_data, 0);

      repeat (4) cyc(1,3,10, 1,3,7, 0,0, 0,0,0,0);
      rd(3, 0);
      chk("tp_sum68", rd_data, 68);
      chk("tp_ovf3", ovf_flag[3], 0);

      sat_mode[7] = 1'b1;
      inc1(7, 250); inc1(7, 10); rd(7, 0);
      chk("tp_sat255", rd_data, 255);
      chk("tp_sat_ovf", ovf_flag[7], 1);
      cyc(0,0,0, 0,0,0, 0,1, 0,0,0,0);
      sat_mode[7] = 1'b0;
      inc1(7, 250); inc1(7, 10); rd(7, 0);
      chk("tp_wrap4", rd_data, 4);
      chk("tp_wrap_ovf", ovf_flag[7], 1);
      cyc(0,0,0, 0,0,0, 0,1, 0,0,0,0);
      rd(7, 0);
      chk("tp_clr_val", rd_data, 0);
      chk("tp_clr_ovf", ovf_flag[7], 0);

      inc1(2, 40);
      cyc(1,2,5, 0,0,0, 1,1, 0,0,0,0);
      rd(2, 1);
      chk("tp_snap40", rd_data, 40);
      rd(2, 0);
      chk("tp_live5", rd_data, 5);

      inc1(9, 100);
      cyc(1,9,3, 0,0,0, 0,0, 1,9,0,1);
      chk("tp_rdclr100", rd_data, 100);
      rd(9, 0);
      chk("tp_rdclr3", rd_data, 3);

      rd(12, 0);
      chk("tp_err_ack", rd_ack, 1);
      chk("tp_err", rd_err, 1);
      chk("tp_err_data", rd_data, 0);

      inc1(1, 20);
      rd(1, 0);
      chk("tp_b2b_1", rd_data, 20);
      rd(2, 0);
      chk("tp_b2b_2", rd_data, 5);

      // clear_live and overflow in the same cycle: flag stays set
      cyc(1,4,200, 1,4,200, 0,1, 0,0,0,0);
      chk("clr_ovf_set", ovf_flag[4], 1);
      rd(4, 0);
      chk("clr_ovf_val", rd_data, 144);

      for (int n = 0; n < 1500; n++) begin
         int a0, a1;
         if (n % 50 == 0) sat_mode = N_CNT'($urandom);
         a0 = ($urandom_range(0,3) == 0) ? $urandom_range(0,255) : $urandom_range(0,15);
         a1 = ($urandom_range(0,3) == 0) ? $urandom_range(0,255) : $urandom_range(0,15);
         cyc($urandom_range(0,1), $urandom_range(0,15), a0,
             $urandom_range(0,1), $urandom_range(0,15), a1,
             ($urandom_range(0,19) == 0), ($urandom_range(0,29) == 0),
             $urandom_range(0,1), $urandom_range(0,15), $urandom_range(0,1), $urandom_range(0,1));
      end

      // Reset landing on a pending read suppresses the ack.
      rd_req = 1'b1; rd_addr = 4'd1; rd_src = 1'b0; rd_clr = 1'b0;
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      chk("rst_mid_ack", rd_ack, 0);
      chk("rst_mid_ovf", ovf_flag, 0);
      rd_req = 1'b0;
      rst = 1'b0;
      idle();
      rd(3, 0);
      chk("post_rst_rd", rd_data, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
